// File: rtl/bayer_frame_ctrl.sv
// bayer_frame_ctrl: frame gating and Bayer phase tracking for a raw sensor
// stream. Arming with enable first discards SKIP_FRAMES warm-up frames and
// then passes whole frames through. Every output is registered, one cycle
// behind the sensor inputs.
// Optional feature: define BAYER_FRAME_CTRL_SIZE_CHECK_EN to enable the sticky
// frame geometry check on size_err. Without it, size_err is tied low.
module bayer_frame_ctrl #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic        in_vsync,
  input  logic        in_href,
  input  logic [1:0]  pattern,
  output logic        out_href,
  output logic        out_vsync,
  output logic        pix_phase,
  output logic        line_phase,
  output logic [11:0] pix_cnt,
  output logic [10:0] line_cnt,
  output logic        frame_start,
  output logic        frame_done,
  output logic        busy,
  output logic        size_err
);

  typedef enum logic [1:0] {IDLE, SYNC, SKIP, ACTIVE} state_t;

  localparam logic [10:0] V_LAST    = 11'(V_ACTIVE - 1);
  localparam logic [3:0]  SKIP_LOAD = 4'(SKIP_FRAMES);

  state_t      state, state_nx;
  logic [3:0]  skip_cnt, skip_nx;
  logic        v_d, h_d;
  logic        vs_rise, h_fall;
  logic        done_flag;
  logic        done_line, done_vs, done_now;
  logic        in_active;

  assign vs_rise   = in_vsync & ~v_d;
  assign h_fall    = ~in_href & h_d;
  assign in_active = (state == ACTIVE);

  // A vsync rise wins over a coincident href fall, so the line-based end
  // condition is masked when both happen on the same cycle.
  assign done_line = in_active & h_fall & ~vs_rise & (line_cnt == V_LAST) & ~done_flag;
  assign done_vs   = in_active & vs_rise & ~done_flag;
  assign done_now  = done_line | done_vs;

  // State and skip counter register.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= IDLE;
      skip_cnt <= 4'd0;
    end else begin
      state    <= state_nx;
      skip_cnt <= skip_nx;
    end
  end

  // Next-state logic: arm, wait for frame boundary, skip warm-up, capture.
  always_comb begin
    state_nx = state;
    skip_nx  = skip_cnt;
    case (state)
      IDLE: begin
        if (enable) state_nx = SYNC;
      end
      SYNC: begin
        if (!enable) begin
          state_nx = IDLE;
        end else if (vs_rise) begin
          if (SKIP_FRAMES == 0) begin
            state_nx = ACTIVE;
          end else begin
            state_nx = SKIP;
            skip_nx  = SKIP_LOAD;
          end
        end
      end
      SKIP: begin
        if (!enable) begin
          state_nx = IDLE;
        end else if (vs_rise) begin
          if (skip_cnt != 4'd0) skip_nx = skip_cnt - 4'd1;
          if (skip_cnt <= 4'd1) state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        // Once disarmed, stay only until the current frame has ended.
        if (!enable && (done_now || done_flag)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Input delay, gated href, frame pulses and busy flag.
  always_ff @(posedge pclk) begin
    if (rst) begin
      v_d         <= 1'b0;
      h_d         <= 1'b0;
      out_href    <= 1'b0;
      out_vsync   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      done_flag   <= 1'b0;
    end else begin
      v_d         <= in_vsync;
      h_d         <= in_href;
      out_href    <= in_active & in_href;
      out_vsync   <= in_vsync;
      frame_start <= vs_rise & (state_nx == ACTIVE);
      frame_done  <= done_now;
      busy        <= (state_nx != IDLE);
      if (vs_rise)        done_flag <= 1'b0;
      else if (done_line) done_flag <= 1'b1;
    end
  end

  // Pixel/line counters and Bayer phases for the pixel currently on out_href.
  always_ff @(posedge pclk) begin
    if (rst) begin
      pix_cnt    <= 12'd0;
      line_cnt   <= 11'd0;
      pix_phase  <= 1'b0;
      line_phase <= 1'b0;
    end else if (vs_rise && state != IDLE) begin
      pix_cnt    <= 12'd0;
      line_cnt   <= 11'd0;
      pix_phase  <= pattern[1];
      line_phase <= pattern[0];
    end else if (h_fall && in_active) begin
      pix_cnt    <= 12'd0;
      if (line_cnt != 11'h7FF) line_cnt <= line_cnt + 11'd1;
      pix_phase  <= pattern[1];
      line_phase <= ~line_phase;
    end else if (out_href) begin
      if (pix_cnt != 12'hFFF) pix_cnt <= pix_cnt + 12'd1;
      pix_phase  <= ~pix_phase;
    end
  end

`ifdef BAYER_FRAME_CTRL_SIZE_CHECK_EN
  localparam logic [11:0] H_EXP = 12'(H_ACTIVE);
  localparam logic [10:0] V_EXP = 11'(V_ACTIVE);

  // pix_cnt still shows the last pixel's index at the href fall, so the
  // pixel total for the line includes the pixel being presented right now.
  logic [11:0] pix_total;
  assign pix_total = (out_href && pix_cnt != 12'hFFF) ? pix_cnt + 12'd1 : pix_cnt;

  // Sticky geometry error on short/long lines and frames while capturing.
  always_ff @(posedge pclk) begin
    if (rst) begin
      size_err <= 1'b0;
    end else if (in_active &&
                 ((vs_rise && line_cnt != V_EXP) ||
                  (h_fall && !vs_rise && pix_total != H_EXP))) begin
      size_err <= 1'b1;
    end
  end
`else
  assign size_err = 1'b0;
`endif

endmodule

// File: tb/tb_bayer_frame_ctrl.sv
// Directed testbench for bayer_frame_ctrl with an 8x4 geometry and two
// warm-up frames. Inputs change 1 ns after a rising edge and outputs are
// sampled 1 ns after the next rising edge.
module tb_bayer_frame_ctrl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        enable;
  logic        in_vsync;
  logic        in_href;
  logic [1:0]  pattern;
  logic        out_href;
  logic        out_vsync;
  logic        pix_phase;
  logic        line_phase;
  logic [11:0] pix_cnt;
  logic [10:0] line_cnt;
  logic        frame_start;
  logic        frame_done;
  logic        busy;
  logic        size_err;

  typedef struct {
    logic        vs;
    logic        href;
    logic        exp_href;
    logic        exp_vsync;
    logic        exp_pp;
    logic        exp_lp;
    logic [11:0] exp_pix;
    logic [10:0] exp_line;
    logic        exp_fs;
    logic        exp_fd;
  } vec_t;

  vec_t vecs [20];

  int checks = 0;
  int errors = 0;
  int href_seen = 0;
  int start_seen = 0;
  int done_seen = 0;
  logic exp_err;

  always #5 pclk = ~pclk;

  bayer_frame_ctrl #(
    .H_ACTIVE(8),
    .V_ACTIVE(4),
    .SKIP_FRAMES(2)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .enable(enable),
    .in_vsync(in_vsync),
    .in_href(in_href),
    .pattern(pattern),
    .out_href(out_href),
    .out_vsync(out_vsync),
    .pix_phase(pix_phase),
    .line_phase(line_phase),
    .pix_cnt(pix_cnt),
    .line_cnt(line_cnt),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .busy(busy),
    .size_err(size_err)
  );

  function automatic vec_t mk(input int vs, input int hr, input int oh, input int ov,
                              input int pp, input int lp, input int pix, input int line,
                              input int fs, input int fd);
    vec_t v;
    v.vs        = 1'(vs);
    v.href      = 1'(hr);
    v.exp_href  = 1'(oh);
    v.exp_vsync = 1'(ov);
    v.exp_pp    = 1'(pp);
    v.exp_lp    = 1'(lp);
    v.exp_pix   = 12'(pix);
    v.exp_line  = 11'(line);
    v.exp_fs    = 1'(fs);
    v.exp_fd    = 1'(fd);
    return v;
  endfunction

  // Drive one cycle of sensor inputs and sample outputs just after the edge.
  task automatic applyStimulus(input logic vs, input logic hr);
    in_vsync = vs;
    in_href  = hr;
    @(posedge pclk);
    #1;
    href_seen  += int'(out_href);
    start_seen += int'(frame_start);
    done_seen  += int'(frame_done);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic runLine(input int npix, input int gap);
    for (int p = 0; p < npix; p++) applyStimulus(1'b0, 1'b1);
    for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic vsyncPulse();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic runFrame(input int lines, input int npix);
    vsyncPulse();
    for (int l = 0; l < lines; l++) runLine(npix, 2);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_out_href"}, out_href, 0);
    checkOutput({tag, "_out_vsync"}, out_vsync, 0);
    checkOutput({tag, "_pix_phase"}, pix_phase, 0);
    checkOutput({tag, "_line_phase"}, line_phase, 0);
    checkOutput({tag, "_pix_cnt"}, pix_cnt, 0);
    checkOutput({tag, "_line_cnt"}, line_cnt, 0);
    checkOutput({tag, "_frame_start"}, frame_start, 0);
    checkOutput({tag, "_frame_done"}, frame_done, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_size_err"}, size_err, 0);
  endtask

  initial begin
`ifdef BAYER_FRAME_CTRL_SIZE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    // pattern 2'b10 frame of 4x2 pixels, then a vsync rise on an href fall.
    vecs[0]  = mk(1, 0,  0, 1, 1, 0, 0, 0, 1, 0);
    vecs[1]  = mk(1, 0,  0, 1, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0,  0, 0, 1, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1,  1, 0, 1, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 1,  1, 0, 0, 0, 1, 0, 0, 0);
    vecs[5]  = mk(0, 1,  1, 0, 1, 0, 2, 0, 0, 0);
    vecs[6]  = mk(0, 1,  1, 0, 0, 0, 3, 0, 0, 0);
    vecs[7]  = mk(0, 0,  0, 0, 1, 1, 0, 1, 0, 0);
    vecs[8]  = mk(0, 0,  0, 0, 1, 1, 0, 1, 0, 0);
    vecs[9]  = mk(0, 1,  1, 0, 1, 1, 0, 1, 0, 0);
    vecs[10] = mk(0, 1,  1, 0, 0, 1, 1, 1, 0, 0);
    vecs[11] = mk(0, 1,  1, 0, 1, 1, 2, 1, 0, 0);
    vecs[12] = mk(0, 1,  1, 0, 0, 1, 3, 1, 0, 0);
    vecs[13] = mk(0, 0,  0, 0, 1, 0, 0, 2, 0, 0);
    vecs[14] = mk(0, 0,  0, 0, 1, 0, 0, 2, 0, 0);
    vecs[15] = mk(0, 1,  1, 0, 1, 0, 0, 2, 0, 0);
    vecs[16] = mk(0, 1,  1, 0, 0, 0, 1, 2, 0, 0);
    vecs[17] = mk(1, 0,  0, 1, 1, 0, 0, 0, 1, 1);
    vecs[18] = mk(1, 0,  0, 1, 1, 0, 0, 0, 0, 0);
    vecs[19] = mk(0, 0,  0, 0, 1, 0, 0, 0, 0, 0);

    rst = 1'b1; enable = 1'b0; pattern = 2'b00;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkAllZero("reset");

    // Four 8x4 frames: two skipped, two captured.
    rst = 1'b0; enable = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("armed_busy", busy, 1);
    done_seen = 0;
    for (int f = 0; f < 4; f++) begin
      href_seen = 0; start_seen = 0;
      runFrame(4, 8);
      checkOutput($sformatf("skip_href_frame%0d", f + 1), href_seen, (f < 2) ? 0 : 32);
      checkOutput($sformatf("skip_start_frame%0d", f + 1), start_seen, (f < 2) ? 0 : 1);
    end
    checkOutput("skip_done_total", done_seen, 2);
    checkOutput("skip_size_err", size_err, 0);

    // Bayer phase sequencing from the vector table.
    pattern = 2'b10;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].vs, vecs[i].href);
      checkOutput($sformatf("vec%0d_out_href", i), out_href, vecs[i].exp_href);
      checkOutput($sformatf("vec%0d_out_vsync", i), out_vsync, vecs[i].exp_vsync);
      checkOutput($sformatf("vec%0d_pix_phase", i), pix_phase, vecs[i].exp_pp);
      checkOutput($sformatf("vec%0d_line_phase", i), line_phase, vecs[i].exp_lp);
      checkOutput($sformatf("vec%0d_pix_cnt", i), pix_cnt, vecs[i].exp_pix);
      checkOutput($sformatf("vec%0d_line_cnt", i), line_cnt, vecs[i].exp_line);
      checkOutput($sformatf("vec%0d_frame_start", i), frame_start, vecs[i].exp_fs);
      checkOutput($sformatf("vec%0d_frame_done", i), frame_done, vecs[i].exp_fd);
      checkOutput($sformatf("vec%0d_busy", i), busy, 1);
    end

    // Enable dropped mid-line: the frame finishes, then the block idles.
    href_seen = 0; start_seen = 0; done_seen = 0;
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 8; p++) begin
        if (l == 0 && p == 3) enable = 1'b0;
        applyStimulus(1'b0, 1'b1);
      end
      if (l == 3) checkOutput("disarm_busy_before_end", busy, 1);
      applyStimulus(1'b0, 1'b0);
      if (l == 3) checkOutput("disarm_done_pulse", frame_done, 1);
      applyStimulus(1'b0, 1'b0);
    end
    checkOutput("disarm_busy_after", busy, 0);
    checkOutput("disarm_done_single", frame_done, 0);
    runFrame(1, 8);
    checkOutput("disarm_href_total", href_seen, 32);
    checkOutput("disarm_done_total", done_seen, 1);
    checkOutput("disarm_start_total", start_seen, 0);

    // Short line with the geometry check: sticky until reset.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkAllZero("rst2");
    rst = 1'b0; enable = 1'b1; pattern = 2'b00;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    vsyncPulse(); vsyncPulse(); vsyncPulse();
    checkOutput("short_busy", busy, 1);
    for (int p = 0; p < 7; p++) applyStimulus(1'b0, 1'b1);
    checkOutput("short_err_before", size_err, 0);
    checkOutput("short_pix_last", pix_cnt, 6);
    applyStimulus(1'b0, 1'b0);
    checkOutput("short_err_set", size_err, exp_err);
    runLine(8, 4);
    checkOutput("short_err_sticky", size_err, exp_err);
    checkOutput("short_line_cnt", line_cnt, 2);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0);
    checkOutput("short_err_cleared", size_err, 0);

    // Reset during the last line of a captured frame.
    rst = 1'b0; enable = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    vsyncPulse(); vsyncPulse(); vsyncPulse();
    for (int l = 0; l < 3; l++) runLine(8, 2);
    for (int p = 0; p < 3; p++) applyStimulus(1'b0, 1'b1);
    checkOutput("midrst_line_before", line_cnt, 3);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1);
    checkAllZero("midrst");
    rst = 1'b0;
    href_seen = 0; done_seen = 0;
    runLine(3, 4);
    checkOutput("midrst_no_done", done_seen, 0);
    checkOutput("midrst_no_href", href_seen, 0);
    checkOutput("midrst_resync_busy", busy, 1);
    checkOutput("midrst_line_cnt", line_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
